iiitb_ring_decoder_chk: RTL
===========================

// Module: iiitb_ring_decoder_chk
// PURPOSE
//  Receive side of the ring-counter interface: samples an N-bit rotate-left one-hot ring
//  (001->010->100->001 for N=3), decodes it to a binary index, and checks one-hot legality
//  and step order. A HUNT/LOCKED state machine reports sync status, counts sequence errors
//  and flags wrap-around. Sits downstream of any ring counter, as a monitor or slot decoder.
// PARAMETERS
//  N        3  ring width in bits, N>=2; IDX_W = $clog2(N)
//  LOCK_CNT 2  consecutive correct steps required in HUNT before entering LOCKED (>=1)
//  ERR_W    8  width of saturating error counter
// PORTS
//  Clock      in   1      rising-edge clock
//  Reset      in   1      synchronous, active-high; priority over all other inputs
//  Ring_in    in   N      ring counter value; bit0 = index 0
//  Ring_valid in   1      Ring_in sampled on this edge when 1; else all state holds
//  Index_out  out  IDX_W  index of set bit of last legal sample
//  Onehot_ok  out  1      last sample was exactly one-hot
//  Locked     out  1      FSM in LOCKED
//  Seq_err    out  1      one-cycle pulse: sequence error detected while LOCKED
//  Wrap_pulse out  1      one-cycle pulse: LOCKED correct step index N-1 -> 0
//  Err_count  out  ERR_W  saturating count of Seq_err pulses
//  Dir_out    out  1      only with RING_DIR_DETECT_EN; 0 = rotate-left, 1 = rotate-right
// BEHAVIOUR
//  - All outputs registered. A sample on edge k is reflected on outputs after edge k (1-cycle latency).
//  - Reset (sync): Index_out=0, Onehot_ok=0, Locked=0, Seq_err=0, Wrap_pulse=0, Err_count=0,
//    Dir_out=0; FSM=HUNT; step count=0; prev_valid=0. Reset asserted with Ring_valid=1: sample discarded.
//  - Ring_valid=0: Index_out, Onehot_ok, Locked, Err_count and FSM hold; Seq_err and Wrap_pulse=0.
//  - Decode: exactly one bit set -> Onehot_ok=1, Index_out=position.
//    Zero or multiple bits set -> Onehot_ok=0, Index_out holds last legal value.
//  - Correct step: sample legal, prev_valid=1, and index = (prev+1) mod N.
//    A hold (same index) or a skip is NOT a correct step.
//  - HUNT:
//    - Legal sample: store as prev and set prev_valid.
//    - Correct step: step count++. When the count reaches LOCK_CNT: FSM=LOCKED, Locked=1, count cleared.
//    - Legal non-correct step: count=0; the sample becomes the new prev.
//    - Illegal sample: count=0, prev_valid=0.
//    - No Seq_err, no Err_count change and no Wrap_pulse in HUNT.
//  - LOCKED:
//    - Correct step: update prev. Wrap_pulse=1 when prev=N-1 and new index=0.
//    - Any other sample (illegal, hold or skip): Seq_err=1 for one cycle, Err_count+1
//      (saturates at 2^ERR_W-1), FSM=HUNT, Locked=0, count=0.
//    - Legal erroring sample: becomes prev, prev_valid=1. Illegal erroring sample: prev_valid=0.
//  - Reset mid-operation: returns to reset values on the next edge; Err_count is cleared.
// CONFIGURATION
//  RING_DIR_DETECT_EN defined:
//    - Correct step is the +1 step (left) or the -1 step (right) mod N.
//    - Direction is latched in HUNT on the first correct step. Later steps must match it;
//      a direction change resets the count and latches the new direction.
//    - In LOCKED, a reverse step is a sequence error.
//    - Dir_out is valid while Locked=1. Right-rotation wrap: Wrap_pulse on 0 -> N-1.
//  RING_DIR_DETECT_EN not defined:
//    - No Dir_out port; only rotate-left steps count as correct; a reverse step is a skip.
// TESTING (N=3, LOCK_CNT=2 unless noted)
//  1. Reset; then Ring_valid=1 with 001,010,100,001 -> Index_out 0,1,2,0; Locked=1 after the 100
//     sample; Wrap_pulse=1 only on the cycle after the final 001.
//  2. While Locked, prev=100, sample 101 -> Onehot_ok=0, Index_out stays 2, Seq_err=1 for one
//     cycle, Err_count=1, Locked=0.
//  3. While Locked, sample 001 then 100 (skip) -> Seq_err=1, Err_count+1, HUNT; then 001,010
//     -> Locked=1 again after 010.
//  4. ERR_W=2: produce 5 LOCKED sequence errors -> Err_count 1,2,3,3,3 (saturated).
//  5. Reset=1 with Ring_valid=1, Ring_in=010 while Locked -> next cycle all outputs at reset
//     values, Index_out=0, Err_count=0.
//  6. Sequence 100,010,001,100: with RING_DIR_DETECT_EN -> Locked=1, Dir_out=1, Wrap_pulse
//     after the final 100, no Seq_err; without it -> Locked never asserts, Err_count=0.

Source files
------------

// File: rtl/iiitb_ring_decoder_chk_if.sv
// Ring sample bus between a ring-counter source (master) and the decoder/checker (slave).
// Dir_out exists only when RING_DIR_DETECT_EN is defined.
interface iiitb_ring_decoder_chk_if #(
  parameter int N     = 3,
  parameter int ERR_W = 8
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     Ring_in;
  logic             Ring_valid;
  logic [IDX_W-1:0] Index_out;
  logic             Onehot_ok;
  logic             Locked;
  logic             Seq_err;
  logic             Wrap_pulse;
  logic [ERR_W-1:0] Err_count;
`ifdef RING_DIR_DETECT_EN
  logic             Dir_out;
`endif

  modport master (
`ifdef RING_DIR_DETECT_EN
    input  Dir_out,
`endif
    output Ring_in, Ring_valid,
    input  Index_out, Onehot_ok, Locked, Seq_err, Wrap_pulse, Err_count
  );

  modport slave (
`ifdef RING_DIR_DETECT_EN
    output Dir_out,
`endif
    input  Ring_in, Ring_valid,
    output Index_out, Onehot_ok, Locked, Seq_err, Wrap_pulse, Err_count
  );
endinterface

// File: rtl/iiitb_ring_decoder_chk.sv
// One-hot ring decoder and step-order checker with HUNT/LOCKED sync tracking.
// Optional RING_DIR_DETECT_EN: accept rotate-right rings too and report direction on Dir_out.
module iiitb_ring_decoder_chk #(
  parameter int N        = 3,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input logic                     Clock,
  input logic                     Reset,
  iiitb_ring_decoder_chk_if.slave ring_if
);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic             onehot_q, onehot_d;
  logic             seq_err_q, seq_err_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
`ifdef RING_DIR_DETECT_EN
  logic             dir_q, dir_d;
  logic             step_dir;
`endif

  // Each bit contributes its own position; OR of terms is the index when one-hot.
  logic [N-1:0][IDX_W-1:0] idx_terms;
  logic [IDX_W-1:0]        dec_idx;
  logic                    legal;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_idx
      assign idx_terms[gi] = ring_if.Ring_in[gi] ? IDX_W'(gi) : '0;
    end
  endgenerate

  always_comb begin
    dec_idx = '0;
    for (int i = 0; i < N; i++) dec_idx = dec_idx | idx_terms[i];
  end

  assign legal = (ring_if.Ring_in != '0) &&
                 ((ring_if.Ring_in & (ring_if.Ring_in - N'(1))) == '0);

  logic [IDX_W-1:0] prev_inc, prev_dec;
  logic             step_fwd, step_rev, hunt_step, lock_step, wrap_hit;
  logic [CNT_W-1:0] cnt_next;

  assign prev_inc = (prev_q == IDX_W'(N - 1)) ? '0 : prev_q + IDX_W'(1);
  assign prev_dec = (prev_q == '0) ? IDX_W'(N - 1) : prev_q - IDX_W'(1);
  assign step_fwd = legal && prev_valid_q && (dec_idx == prev_inc);
  assign step_rev = legal && prev_valid_q && (dec_idx == prev_dec);

`ifdef RING_DIR_DETECT_EN
  // For N=2 both directions coincide; keep the latched direction then.
  assign step_dir  = (step_fwd && step_rev) ? dir_q : step_rev;
  assign hunt_step = step_fwd || step_rev;
  assign lock_step = dir_q ? step_rev : step_fwd;
  assign wrap_hit  = dir_q ? (prev_q == '0) : (prev_q == IDX_W'(N - 1));
`else
  assign hunt_step = step_fwd;
  assign lock_step = step_fwd;
  assign wrap_hit  = (prev_q == IDX_W'(N - 1));
`endif

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    onehot_d     = onehot_q;
    seq_err_d    = 1'b0;
    wrap_d       = 1'b0;
    cnt_d        = cnt_q;
    err_d        = err_q;
    cnt_next     = cnt_q + CNT_W'(1);
`ifdef RING_DIR_DETECT_EN
    dir_d        = dir_q;
`endif
    if (ring_if.Ring_valid) begin
      onehot_d     = legal;
      prev_valid_d = legal;
      if (legal) begin
        index_d = dec_idx;
        prev_d  = dec_idx;
      end
      case (state_q)
        HUNT: begin
          if (hunt_step) begin
`ifdef RING_DIR_DETECT_EN
            if (cnt_q != '0 && step_dir != dir_q) cnt_next = CNT_W'(1);
            dir_d = step_dir;
`endif
            if (cnt_next == CNT_W'(LOCK_CNT)) begin
              state_d = LOCKED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_next;
            end
          end else begin
            cnt_d = '0;
          end
        end
        LOCKED: begin
          if (lock_step) begin
            wrap_d = wrap_hit;
          end else begin
            seq_err_d = 1'b1;
            state_d   = HUNT;
            cnt_d     = '0;
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= HUNT;
      index_q      <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      onehot_q     <= 1'b0;
      seq_err_q    <= 1'b0;
      wrap_q       <= 1'b0;
      cnt_q        <= '0;
      err_q        <= '0;
`ifdef RING_DIR_DETECT_EN
      dir_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      onehot_q     <= onehot_d;
      seq_err_q    <= seq_err_d;
      wrap_q       <= wrap_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`ifdef RING_DIR_DETECT_EN
      dir_q        <= dir_d;
`endif
    end
  end

  assign ring_if.Index_out  = index_q;
  assign ring_if.Onehot_ok  = onehot_q;
  assign ring_if.Locked     = (state_q == LOCKED);
  assign ring_if.Seq_err    = seq_err_q;
  assign ring_if.Wrap_pulse = wrap_q;
  assign ring_if.Err_count  = err_q;
`ifdef RING_DIR_DETECT_EN
  assign ring_if.Dir_out    = dir_q;
`endif
endmodule
